conv_wb_loader: RTL and testbench
=================================

Name: conv_wb_loader

Overview:
- Configuration sequencer for one convolution layer block. Accepts a flat word stream of filter weights and biases over a valid/ready handshake.
- Distributes each word to the correct unit's weight memory or bias memory through the riscv_data / riscv_address / wm_enable_write / bm_enable_write bus.
- Raises conv_ready once the whole layer is loaded.
- Sits between the RISC-V/DMA side and the conv layer top. Owns that layer's write port.

Parameters:
- DATA_WIDTH, 32, width of weight/bias words.
- ADDRESS_BITS, 15, width of riscv_address.
- IFM_DEPTH, 3, input channels per filter.
- KERNAL_SIZE, 5, kernel edge length.
- NUMBER_OF_FILTERS, 6, filters in the layer.
- NUMBER_OF_UNITS, 3, parallel conv units; filter f maps to unit f % NUMBER_OF_UNITS, slot f / NUMBER_OF_UNITS.
- WORDS_PER_FILTER, KERNAL_SIZE*KERNAL_SIZE*IFM_DEPTH, weights per filter (default 75).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_start  in  1  one-cycle pulse; begins a load sequence.
- in_valid  in  1  stream word valid.
- in_data  in  DATA_WIDTH  stream word.
- in_ready  out  1  loader accepts a word this cycle.
- riscv_data  out  DATA_WIDTH  registered write data to the layer.
- riscv_address  out  ADDRESS_BITS  registered write address (zero-extended).
- wm_enable_write  out  NUMBER_OF_UNITS  one-hot weight-memory write strobe.
- bm_enable_write  out  NUMBER_OF_UNITS  one-hot bias-memory write strobe.
- conv_ready  out  1  layer fully configured.
- busy  out  1  load sequence in progress.
- load_checksum  out  DATA_WIDTH  see Optional Feature.

Behaviour:
- Reset values: in_ready=0, riscv_data=0, riscv_address=0, both strobes=0, conv_ready=0, busy=0, load_checksum=0, all counters=0, state=IDLE.
- Reset has effect immediately at any time, including mid-load. No partial-load state survives; conv_ready stays 0 until a complete new load.
- FSM states: IDLE, LOAD_W, LOAD_B, READY.
- IDLE: load_start -> LOAD_W; clear filter counter f, word counter w, checksum.
- LOAD_W: in_ready=1, busy=1. Each beat with in_valid&in_ready (accepted beat):
  - riscv_address <= (f/NUMBER_OF_UNITS)*WORDS_PER_FILTER + w.
  - wm_enable_write <= 1<<(f%NUMBER_OF_UNITS).
  - w++.
  - After w==WORDS_PER_FILTER-1 is accepted: w<=0, go to LOAD_B.
- LOAD_B: in_ready=1. On one accepted beat:
  - riscv_address <= f/NUMBER_OF_UNITS.
  - bm_enable_write <= 1<<(f%NUMBER_OF_UNITS).
  - If f==NUMBER_OF_FILTERS-1: go to READY. Otherwise f++ and go to LOAD_W.
- Stream order is therefore W(f0)[0..74], B(f0), W(f1)..., B(f5); 456 beats at default parameters.
- Write latency: outputs are registered. riscv_data/address/strobe are valid exactly 1 cycle after the accepting edge. Strobes are 1-cycle pulses; with no accepted beat, both strobes are 0 and data/address hold their values.
- in_valid low stalls the sequence indefinitely with no write issued.
- READY: in_ready=0, busy=0. conv_ready rises in the cycle after the final bias strobe is issued, so the last write lands before or with conv_ready.
- load_start in READY: conv_ready=0 next cycle, restart as from IDLE.
- load_start while busy: ignored.
- in_valid while in IDLE or READY: ignored, no strobe.
- Uneven split when NUMBER_OF_FILTERS % NUMBER_OF_UNITS != 0: some units get fewer slots. The mapping rule still holds.
- Address arithmetic is computed at full width, then truncated to ADDRESS_BITS.

Optional Feature:
- Macro: CONV_WB_LOADER_CHECKSUM_EN.
- Defined: load_checksum accumulates, modulo 2^DATA_WIDTH, the sum of every accepted in_data since the last load_start. It is cleared on load_start and held in READY.
- Undefined: load_checksum is tied to 0 and no accumulator is synthesized.

Test Plan:
- Reset, then load_start, then 456 consecutive valid beats with data=index. Required: the beat for filter 4 weight 10 produces wm_enable_write=3'b010 and address 85; the beat for the filter 5 bias produces bm_enable_write=3'b100 and address 1. conv_ready=1 exactly 2 cycles after the last accepted beat.
- in_valid toggling 1/0 every cycle across a full load. Required: strobe count is 450 wm plus 6 bm, with no strobe in any idle-valid cycle; the address sequence is identical to the back-to-back case.
- reset asserted at beat 200. Required: all outputs return to 0 asynchronously without waiting for a clock edge. A following full load completes normally and conv_ready=1.
- load_start pulsed at beat 50 and again in READY. Required: the first pulse is ignored and the load continues; the second pulse drops conv_ready the next cycle and in_ready=1.
- Configuration NUMBER_OF_FILTERS=16, NUMBER_OF_UNITS=3, IFM_DEPTH=6. Required: filter 15 lands on unit 0, slot 5, weight base address 750.
- With CONV_WB_LOADER_CHECKSUM_EN defined and data=index: load_checksum=103740 in READY. With the macro undefined: load_checksum stays 0.

Source files
------------

// File: rtl/conv_wb_loader.sv
// Configuration sequencer that streams one conv layer's weights and biases into per-unit memories.
// Optional running checksum of accepted words: define CONV_WB_LOADER_CHECKSUM_EN.
module conv_wb_loader #(
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned ADDRESS_BITS      = 15,
    parameter int unsigned IFM_DEPTH         = 3,
    parameter int unsigned KERNAL_SIZE       = 5,
    parameter int unsigned NUMBER_OF_FILTERS = 6,
    parameter int unsigned NUMBER_OF_UNITS   = 3,
    parameter int unsigned WORDS_PER_FILTER  = KERNAL_SIZE * KERNAL_SIZE * IFM_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_start,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       in_ready,
    output logic [DATA_WIDTH-1:0]      riscv_data,
    output logic [ADDRESS_BITS-1:0]    riscv_address,
    output logic [NUMBER_OF_UNITS-1:0] wm_enable_write,
    output logic [NUMBER_OF_UNITS-1:0] bm_enable_write,
    output logic                       conv_ready,
    output logic                       busy,
    output logic [DATA_WIDTH-1:0]      load_checksum
);

    localparam int unsigned SLOTS  = (NUMBER_OF_FILTERS + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS;
    localparam int unsigned F_W    = (NUMBER_OF_FILTERS > 1) ? $clog2(NUMBER_OF_FILTERS) : 1;
    localparam int unsigned W_W    = (WORDS_PER_FILTER > 1) ? $clog2(WORDS_PER_FILTER) : 1;
    localparam int unsigned U_W    = (NUMBER_OF_UNITS > 1) ? $clog2(NUMBER_OF_UNITS) : 1;
    localparam int unsigned S_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned CALC_W = 32;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD_W = 2'd1;
    localparam logic [1:0] LOAD_B = 2'd2;
    localparam logic [1:0] READY  = 2'd3;

    logic [1:0]                 state, state_n;
    logic [F_W-1:0]             f, f_n;
    logic [W_W-1:0]             w, w_n;
    logic [U_W-1:0]             unit, unit_n;
    logic [S_W-1:0]             slot, slot_n;
    logic [CALC_W-1:0]          base, base_n;
    logic [DATA_WIDTH-1:0]      data_n;
    logic [ADDRESS_BITS-1:0]    addr_n;
    logic [NUMBER_OF_UNITS-1:0] wm_n, bm_n;
    logic                       in_ready_n, busy_n, conv_ready_n;
    logic                       accept;
    logic                       start_ok;

    assign accept   = in_valid & in_ready;
    assign start_ok = load_start & ((state == IDLE) | (state == READY));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            f               <= '0;
            w               <= '0;
            unit            <= '0;
            slot            <= '0;
            base            <= '0;
            riscv_data      <= '0;
            riscv_address   <= '0;
            wm_enable_write <= '0;
            bm_enable_write <= '0;
            in_ready        <= 1'b0;
            busy            <= 1'b0;
            conv_ready      <= 1'b0;
        end else begin
            state           <= state_n;
            f               <= f_n;
            w               <= w_n;
            unit            <= unit_n;
            slot            <= slot_n;
            base            <= base_n;
            riscv_data      <= data_n;
            riscv_address   <= addr_n;
            wm_enable_write <= wm_n;
            bm_enable_write <= bm_n;
            in_ready        <= in_ready_n;
            busy            <= busy_n;
            conv_ready      <= conv_ready_n;
        end
    end

    // Unit/slot/base track f % units, f / units and slot*WORDS_PER_FILTER without dividers.
    always_comb begin
        state_n = state;
        f_n     = f;
        w_n     = w;
        unit_n  = unit;
        slot_n  = slot;
        base_n  = base;
        data_n  = riscv_data;
        addr_n  = riscv_address;
        wm_n    = '0;
        bm_n    = '0;

        case (state)
            IDLE, READY: begin
                if (load_start) begin
                    state_n = LOAD_W;
                    f_n     = '0;
                    w_n     = '0;
                    unit_n  = '0;
                    slot_n  = '0;
                    base_n  = '0;
                end
            end
            LOAD_W: begin
                if (accept) begin
                    data_n = in_data;
                    addr_n = ADDRESS_BITS'(base + CALC_W'(w));
                    wm_n   = NUMBER_OF_UNITS'(1) << unit;
                    if (w == W_W'(WORDS_PER_FILTER - 1)) begin
                        w_n     = '0;
                        state_n = LOAD_B;
                    end else begin
                        w_n = w + W_W'(1);
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    data_n = in_data;
                    addr_n = ADDRESS_BITS'(slot);
                    bm_n   = NUMBER_OF_UNITS'(1) << unit;
                    if (f == F_W'(NUMBER_OF_FILTERS - 1)) begin
                        state_n = READY;
                    end else begin
                        state_n = LOAD_W;
                        f_n     = f + F_W'(1);
                        if (unit == U_W'(NUMBER_OF_UNITS - 1)) begin
                            unit_n = '0;
                            slot_n = slot + S_W'(1);
                            base_n = base + CALC_W'(WORDS_PER_FILTER);
                        end else begin
                            unit_n = unit + U_W'(1);
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        in_ready_n   = (state_n == LOAD_W) || (state_n == LOAD_B);
        busy_n       = in_ready_n;
        conv_ready_n = (state == READY) && !load_start;
    end

`ifdef CONV_WB_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (start_ok) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + in_data;
        end
    end

    assign load_checksum = sum_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign load_checksum   = '0;
`endif

endmodule

// File: tb/tb_conv_wb_loader.sv
// Directed bench for conv_wb_loader: default layer plus a 16-filter / 6-channel configuration.
module tb_conv_wb_loader;

    localparam int BEATS   = 456;
    localparam int PER_F   = 76;
    localparam int C_PER_F = 151;
    localparam int C_BEATS = 16 * C_PER_F;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start, in_valid;
    logic [31:0] in_data;
    logic        in_ready, conv_ready, busy;
    logic [31:0] riscv_data, load_checksum;
    logic [14:0] riscv_address;
    logic [2:0]  wm_enable_write, bm_enable_write;

    logic        c_load_start, c_in_valid;
    logic [31:0] c_in_data;
    logic        c_in_ready, c_conv_ready, c_busy;
    logic [31:0] c_riscv_data, c_load_checksum;
    logic [14:0] c_riscv_address;
    logic [2:0]  c_wm, c_bm;

    int vectors = 0;
    int miscompares = 0;
    int wm_cnt = 0;
    int bm_cnt = 0;

    always #5 clk = ~clk;

    conv_wb_loader dut (
        .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .riscv_data(riscv_data),
        .riscv_address(riscv_address), .wm_enable_write(wm_enable_write),
        .bm_enable_write(bm_enable_write), .conv_ready(conv_ready), .busy(busy),
        .load_checksum(load_checksum)
    );

    conv_wb_loader #(.NUMBER_OF_FILTERS(16), .NUMBER_OF_UNITS(3), .IFM_DEPTH(6)) dut16 (
        .clk(clk), .reset(reset), .load_start(c_load_start), .in_valid(c_in_valid),
        .in_data(c_in_data), .in_ready(c_in_ready), .riscv_data(c_riscv_data),
        .riscv_address(c_riscv_address), .wm_enable_write(c_wm),
        .bm_enable_write(c_bm), .conv_ready(c_conv_ready), .busy(c_busy),
        .load_checksum(c_load_checksum)
    );

    always @(negedge clk) begin
        if (|wm_enable_write) wm_cnt++;
        if (|bm_enable_write) bm_cnt++;
    end

    task automatic check_all_zero(input string name);
        vectors++;
        if (in_ready !== 1'b0 || riscv_data !== 32'd0 || riscv_address !== 15'd0 ||
            wm_enable_write !== 3'd0 || bm_enable_write !== 3'd0 || conv_ready !== 1'b0 ||
            busy !== 1'b0 || load_checksum !== 32'd0) begin
            miscompares++;
            $display("FAIL %s: rdy=%b data=%0d addr=%0d wm=%b bm=%b cr=%b busy=%b sum=%0d, required all zero",
                     name, in_ready, riscv_data, riscv_address, wm_enable_write, bm_enable_write,
                     conv_ready, busy, load_checksum);
        end
    endtask

    // Full or partial load on the default instance; caller sits at posedge+1.
    task automatic do_load(input bit toggle, input int pulse_at, input int stop_at);
        int f, r, exp_addr;
        logic [2:0] exp_wm, exp_bm;
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || conv_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL start: rdy=%b busy=%b cr=%b, required 1 1 0", in_ready, busy, conv_ready);
        end
        for (int i = 0; i < BEATS; i++) begin
            in_valid   = 1'b1;
            in_data    = 32'(i);
            load_start = (i == pulse_at);
            @(posedge clk); #1;
            in_valid   = 1'b0;
            load_start = 1'b0;
            f = i / PER_F;
            r = i % PER_F;
            if (r < 75) begin
                exp_addr = (f / 3) * 75 + r;
                exp_wm   = 3'b001 << (f % 3);
                exp_bm   = 3'b000;
            end else begin
                exp_addr = f / 3;
                exp_wm   = 3'b000;
                exp_bm   = 3'b001 << (f % 3);
            end
            vectors++;
            if (riscv_address !== 15'(exp_addr) || wm_enable_write !== exp_wm ||
                bm_enable_write !== exp_bm || riscv_data !== 32'(i)) begin
                miscompares++;
                $display("FAIL beat%0d: addr=%0d wm=%b bm=%b data=%0d required addr=%0d wm=%b bm=%b data=%0d",
                         i, riscv_address, wm_enable_write, bm_enable_write, riscv_data,
                         exp_addr, exp_wm, exp_bm, i);
            end
            if (i == 314) begin
                vectors++;
                if (wm_enable_write !== 3'b010 || riscv_address !== 15'd85) begin
                    miscompares++;
                    $display("FAIL f4w10: wm=%b addr=%0d required 010 85", wm_enable_write, riscv_address);
                end
            end
            if (i == BEATS - 1) begin
                vectors++;
                if (bm_enable_write !== 3'b100 || riscv_address !== 15'd1 || conv_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL f5bias: bm=%b addr=%0d cr=%b required 100 1 0",
                             bm_enable_write, riscv_address, conv_ready);
                end
            end
            if (i == stop_at) return;
            if (toggle && i < BEATS - 1) begin
                @(posedge clk); #1;
                vectors++;
                if (wm_enable_write !== 3'd0 || bm_enable_write !== 3'd0 || riscv_data !== 32'(i)) begin
                    miscompares++;
                    $display("FAIL idle%0d: wm=%b bm=%b data=%0d required 000 000 %0d",
                             i, wm_enable_write, bm_enable_write, riscv_data, i);
                end
            end
        end
        @(posedge clk); #1;
        vectors++;
        if (conv_ready !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 ||
            wm_enable_write !== 3'd0 || bm_enable_write !== 3'd0) begin
            miscompares++;
            $display("FAIL ready: cr=%b rdy=%b busy=%b wm=%b bm=%b required 1 0 0 000 000",
                     conv_ready, in_ready, busy, wm_enable_write, bm_enable_write);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = '0;
        c_load_start = 1'b0; c_in_valid = 1'b0; c_in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("in_reset");
        reset = 1'b0;
        in_valid = 1'b1; in_data = 32'd99;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_all_zero("idle_valid_ignored");
    endtask

    task automatic test_back_to_back();
        do_load(1'b0, -1, -1);
    endtask

    task automatic test_toggle();
        wm_cnt = 0;
        bm_cnt = 0;
        do_load(1'b1, -1, -1);
        vectors++;
        if (wm_cnt != 450 || bm_cnt != 6) begin
            miscompares++;
            $display("FAIL strobe_count: wm=%0d bm=%0d required 450 6", wm_cnt, bm_cnt);
        end
    endtask

    task automatic test_load_start();
        do_load(1'b0, 50, -1);
        in_valid = 1'b1; in_data = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if (wm_enable_write !== 3'd0 || bm_enable_write !== 3'd0 || riscv_data !== 32'd455 ||
            conv_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_valid_ignored: wm=%b bm=%b data=%0d cr=%b required 000 000 455 1",
                     wm_enable_write, bm_enable_write, riscv_data, conv_ready);
        end
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        vectors++;
        if (conv_ready !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1 || load_checksum !== 32'd0) begin
            miscompares++;
            $display("FAIL restart: cr=%b rdy=%b busy=%b sum=%0d required 0 1 1 0",
                     conv_ready, in_ready, busy, load_checksum);
        end
    endtask

    task automatic test_abort();
        do_load(1'b0, -1, 200);
        #2 reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        check_all_zero("after_reset");
        do_load(1'b0, -1, -1);
    endtask

    task automatic test_checksum();
        logic [31:0] exp_sum;
`ifdef CONV_WB_LOADER_CHECKSUM_EN
        exp_sum = 32'd103740;
`else
        exp_sum = 32'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (load_checksum !== exp_sum || conv_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL checksum: sum=%0d cr=%b required %0d 1", load_checksum, conv_ready, exp_sum);
        end
    endtask

    task automatic test_config16();
        c_load_start = 1'b1;
        @(posedge clk); #1;
        c_load_start = 1'b0;
        for (int i = 0; i < C_BEATS; i++) begin
            c_in_valid = 1'b1;
            c_in_data  = 32'(i);
            @(posedge clk); #1;
            c_in_valid = 1'b0;
            if (i == 13 * C_PER_F) begin
                vectors++;
                if (c_wm !== 3'b010 || c_riscv_address !== 15'd600) begin
                    miscompares++;
                    $display("FAIL c_f13w0: wm=%b addr=%0d required 010 600", c_wm, c_riscv_address);
                end
            end
            if (i == 15 * C_PER_F) begin
                vectors++;
                if (c_wm !== 3'b001 || c_riscv_address !== 15'd750) begin
                    miscompares++;
                    $display("FAIL c_f15w0: wm=%b addr=%0d required 001 750", c_wm, c_riscv_address);
                end
            end
            if (i == 15 * C_PER_F + 149) begin
                vectors++;
                if (c_wm !== 3'b001 || c_riscv_address !== 15'd899) begin
                    miscompares++;
                    $display("FAIL c_f15w149: wm=%b addr=%0d required 001 899", c_wm, c_riscv_address);
                end
            end
            if (i == C_BEATS - 1) begin
                vectors++;
                if (c_bm !== 3'b001 || c_wm !== 3'b000 || c_riscv_address !== 15'd5 || c_conv_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL c_f15bias: bm=%b wm=%b addr=%0d cr=%b required 001 000 5 0",
                             c_bm, c_wm, c_riscv_address, c_conv_ready);
                end
            end
        end
        @(posedge clk); #1;
        vectors++;
        if (c_conv_ready !== 1'b1 || c_in_ready !== 1'b0 || c_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL c_ready: cr=%b rdy=%b busy=%b required 1 0 0", c_conv_ready, c_in_ready, c_busy);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_toggle();
        test_load_start();
        test_abort();
        test_checksum();
        test_config16();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
